batch_scheduler: RTL
====================

// Module: batch_scheduler
//
// PURPOSE
// Top-level sequencer for the augmentation pipeline. Loads the convolution kernel
// once, then steps a batch of images through read -> augment -> convolve -> write.
// Only one image is in flight at a time, because the augmentation BRAMs are single-image.
// Sits between the PS command registers and the read_module / end-result write_module;
// issues per-image start pulses and BRAM base addresses, and counts pixels to detect
// image completion. Reports busy/done/error back to the PS.
//
// PARAMETERS
// ADDR_WIDTH_PS   32        width of image_addr (PS-side BRAM address)
// NUM_IMAGES      16        maximum images per batch
// NUM_PIXELS      784       pixels per image, counted on both input and output side
// IMAGE_BASE_ADDR 32'h24    BRAM buffer address of image 0
// IMAGE_STRIDE    32'h310   address increment per image
// TIMEOUT_CYCLES  4096      watchdog limit on cycles without progress
// (derived) CW = $clog2(NUM_IMAGES+1);  PW = $clog2(NUM_PIXELS+1)
//
// PORTS
// clk              in   1              system clock
// reset            in   1              synchronous, active-high reset
// cmd_load_kernel  in   1              pulse: load kernel (accepted in IDLE only)
// cmd_start        in   1              pulse: start batch (accepted in IDLE only)
// cmd_num_images   in   CW             images in batch, sampled with cmd_start
// cmd_abort        in   1              pulse: abandon current operation
// read_kernel      out  1              one-cycle kernel-read request to reader
// kernel_loaded    in   1              pulse from reader: kernel registers valid
// read_image       out  1              one-cycle image-read request to reader
// image_addr       out  ADDR_WIDTH_PS  base address of the current image
// in_pixel_valid   in   1              reader pixel strobe (input-side count)
// out_pixel_valid  in   1              convolved pixel strobe to end writer (output-side count)
// image_idx        out  CW             index of the image currently in flight
// busy             out  1              high while not in IDLE
// done             out  1              one-cycle pulse: batch finished (ok or error)
// error            out  1              sticky; cleared by next accepted cmd_start/cmd_load_kernel
//
// BEHAVIOUR
// - Reset: state=IDLE; every output 0; image_addr=IMAGE_BASE_ADDR; counters and kernel_ok cleared.
// - All outputs are registered. States: IDLE, KERNEL, ISSUE, STREAM, NEXT, DONE.
// - IDLE: cmd_load_kernel has priority over cmd_start in the same cycle; the start is dropped.
//   - Load accepted -> KERNEL; read_kernel=1 for the first KERNEL cycle only.
//   - Start accepted with kernel_ok=0, num=0, or num>NUM_IMAGES -> DONE with error=1.
//   - Otherwise -> ISSUE with idx=0 and image_addr=IMAGE_BASE_ADDR.
// - KERNEL: on kernel_loaded, set kernel_ok=1 -> IDLE. No done pulse for a kernel load.
// - ISSUE: read_image=1 for exactly this cycle; pixel counters cleared -> STREAM.
//   - read_image rises in the cycle after cmd_start is sampled.
// - STREAM: in_cnt increments on in_pixel_valid, out_cnt on out_pixel_valid.
//   - in_pixel_valid arriving with in_cnt==NUM_PIXELS: ignored, error=1, run continues.
//   - out_cnt reaching NUM_PIXELS -> NEXT.
// - NEXT: idx+1, image_addr+=IMAGE_STRIDE (wraps modulo 2^ADDR_WIDTH_PS).
//   - If idx+1==num -> DONE, else -> ISSUE.
// - DONE: done=1 for one cycle -> IDLE; busy drops the following cycle.
//   - Final out_pixel_valid sampled at edge M: NEXT in M+1, done in M+2.
// - Watchdog: counter cleared on any valid strobe or state change.
//   - Reaching TIMEOUT_CYCLES in KERNEL or STREAM: error=1 -> DONE.
// - cmd_abort in any non-IDLE state -> IDLE next cycle.
//   - No done pulse; counters, idx and image_addr reset; error unchanged; kernel_ok kept,
//     except when aborted in KERNEL.
// - Strobes while in IDLE/DONE are ignored. Reset mid-batch behaves as a full reset.
//
// TESTING
// 1. load_kernel, kernel_loaded after 10 cycles, start num=2; 784 in/out strobes per image
//    -> two read_image pulses at addr 0x24 and 0x334; done once; error=0.
// 2. start before any kernel load -> done 1 cycle after IDLE exit, error=1, no read_image.
// 3. start with num=0 and with num=17 -> error=1, done, no read_image.
// 4. Stall out_pixel_valid after 500 pixels for 4096 cycles -> error=1, done pulse, busy=0.
// 5. abort during STREAM of image 1 -> IDLE next cycle, no done, image_addr=0x24;
//    restart with num=1 completes cleanly.
// 6. load_kernel and start in the same cycle -> only read_kernel pulses; start ignored;
//    785th in_pixel_valid -> error=1.

Source files
------------

// File: rtl/batch_scheduler.sv
// batch_scheduler
//
// Top-level sequencer for the augmentation pipeline. Loads the convolution
// kernel once, then walks a batch of images through read -> augment ->
// convolve -> write, one image in flight at a time (the augmentation BRAMs
// only hold a single image). Pixel strobes on the reader side and on the
// end-writer side are counted to detect image completion. A watchdog turns
// a stalled kernel load or image stream into an error-terminated batch.
//
// Ports
//   clk              system clock
//   reset            synchronous, active-high reset
//   cmd_load_kernel  pulse from PS: load kernel (accepted in IDLE only)
//   cmd_start        pulse from PS: start batch (accepted in IDLE only)
//   cmd_num_images   images in batch, sampled together with cmd_start
//   cmd_abort        pulse from PS: abandon the current operation
//   read_kernel      one-cycle kernel-read request to the reader
//   kernel_loaded    pulse from reader: kernel registers are valid
//   read_image       one-cycle image-read request to the reader
//   image_addr       BRAM base address of the current image
//   in_pixel_valid   reader pixel strobe (input-side count)
//   out_pixel_valid  convolved pixel strobe to end writer (output-side count)
//   image_idx        index of the image currently in flight
//   busy             high while not in IDLE
//   done             one-cycle pulse: batch finished (ok or error)
//   error            sticky; cleared by the next accepted start/load command
//
// Every output is a register. The always_comb block computes the next value
// of every piece of state; the pulse outputs are derived from next_state so
// they line up with the first cycle of the state they belong to.

module batch_scheduler #(
  parameter int                 ADDR_WIDTH_PS   = 32,
  parameter int                 NUM_IMAGES      = 16,
  parameter int                 NUM_PIXELS      = 784,
  parameter logic [ADDR_WIDTH_PS-1:0] IMAGE_BASE_ADDR = 'h24,
  parameter logic [ADDR_WIDTH_PS-1:0] IMAGE_STRIDE    = 'h310,
  parameter int                 TIMEOUT_CYCLES  = 4096,
  localparam int                CW = $clog2(NUM_IMAGES + 1),
  localparam int                PW = $clog2(NUM_PIXELS + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_load_kernel,
  input  logic                     cmd_start,
  input  logic [CW-1:0]            cmd_num_images,
  input  logic                     cmd_abort,
  output logic                     read_kernel,
  input  logic                     kernel_loaded,
  output logic                     read_image,
  output logic [ADDR_WIDTH_PS-1:0] image_addr,
  input  logic                     in_pixel_valid,
  input  logic                     out_pixel_valid,
  output logic [CW-1:0]            image_idx,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] MAX_IMAGES   = CW'(NUM_IMAGES);
  localparam logic [PW-1:0] PIXELS_FULL  = PW'(NUM_PIXELS);
  localparam logic [PW-1:0] PIXELS_LAST  = PW'(NUM_PIXELS - 1);
  localparam logic [WW-1:0] WD_LAST      = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    KERNEL,
    ISSUE,
    STREAM,
    NEXT,
    DONE
  } state_t;

  state_t                   state, state_nxt;
  logic                     kernel_ok, kernel_ok_nxt;
  logic [CW-1:0]            num, num_nxt;
  logic [CW-1:0]            idx_nxt;
  logic [ADDR_WIDTH_PS-1:0] addr_nxt;
  logic [PW-1:0]            in_cnt, in_cnt_nxt;
  logic [PW-1:0]            out_cnt, out_cnt_nxt;
  logic [WW-1:0]            wd_cnt, wd_cnt_nxt;
  logic                     error_nxt;
  logic [CW-1:0]            idx_plus_one;

  assign idx_plus_one = image_idx + CW'(1);

  // Next-state and next-register computation. The watchdog defaults to zero
  // so that it is cleared by every state change and only counts up while a
  // KERNEL or STREAM cycle passes without any strobe.
  always_comb begin
    state_nxt     = state;
    kernel_ok_nxt = kernel_ok;
    num_nxt       = num;
    idx_nxt       = image_idx;
    addr_nxt      = image_addr;
    in_cnt_nxt    = in_cnt;
    out_cnt_nxt   = out_cnt;
    wd_cnt_nxt    = '0;
    error_nxt     = error;

    unique case (state)
      IDLE: begin
        // A load request wins over a start request in the same cycle.
        if (cmd_load_kernel) begin
          state_nxt     = KERNEL;
          kernel_ok_nxt = 1'b0;
          error_nxt     = 1'b0;
        end else if (cmd_start) begin
          num_nxt  = cmd_num_images;
          idx_nxt  = '0;
          addr_nxt = IMAGE_BASE_ADDR;
          if (!kernel_ok || cmd_num_images == '0 ||
              cmd_num_images > MAX_IMAGES) begin
            state_nxt = DONE;
            error_nxt = 1'b1;
          end else begin
            state_nxt = ISSUE;
            error_nxt = 1'b0;
          end
        end
      end

      KERNEL: begin
        if (kernel_loaded) begin
          kernel_ok_nxt = 1'b1;
          state_nxt     = IDLE;
        end else if (wd_cnt == WD_LAST) begin
          error_nxt = 1'b1;
          state_nxt = DONE;
        end else begin
          wd_cnt_nxt = wd_cnt + WW'(1);
        end
      end

      ISSUE: begin
        in_cnt_nxt  = '0;
        out_cnt_nxt = '0;
        state_nxt   = STREAM;
      end

      STREAM: begin
        // An input strobe beyond a full image is dropped and flagged, but
        // the image keeps going so the writer side can still drain.
        if (in_pixel_valid) begin
          if (in_cnt == PIXELS_FULL) begin
            error_nxt = 1'b1;
          end else begin
            in_cnt_nxt = in_cnt + PW'(1);
          end
        end
        if (out_pixel_valid) begin
          out_cnt_nxt = out_cnt + PW'(1);
          if (out_cnt == PIXELS_LAST) begin
            state_nxt = NEXT;
          end
        end
        if (!in_pixel_valid && !out_pixel_valid) begin
          if (wd_cnt == WD_LAST) begin
            error_nxt = 1'b1;
            state_nxt = DONE;
          end else begin
            wd_cnt_nxt = wd_cnt + WW'(1);
          end
        end
      end

      NEXT: begin
        idx_nxt  = idx_plus_one;
        addr_nxt = image_addr + IMAGE_STRIDE;
        if (idx_plus_one == num) begin
          state_nxt = DONE;
        end else begin
          state_nxt = ISSUE;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Abort overrides whatever the state logic decided. The error flag is
    // left alone; the kernel stays valid unless the load itself was aborted
    // (kernel_ok was already cleared when that load was accepted).
    if (cmd_abort && state != IDLE) begin
      state_nxt     = IDLE;
      kernel_ok_nxt = (state == KERNEL) ? 1'b0 : kernel_ok;
      idx_nxt       = '0;
      addr_nxt      = IMAGE_BASE_ADDR;
      in_cnt_nxt    = '0;
      out_cnt_nxt   = '0;
      wd_cnt_nxt    = '0;
      error_nxt     = error;
    end
  end

  // State and output registers. Pulse outputs look at next_state so that
  // read_kernel/read_image/done are high during the first cycle of their
  // state, and busy falls in the same cycle the FSM is back in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      kernel_ok   <= 1'b0;
      num         <= '0;
      image_idx   <= '0;
      image_addr  <= IMAGE_BASE_ADDR;
      in_cnt      <= '0;
      out_cnt     <= '0;
      wd_cnt      <= '0;
      error       <= 1'b0;
      read_kernel <= 1'b0;
      read_image  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      kernel_ok   <= kernel_ok_nxt;
      num         <= num_nxt;
      image_idx   <= idx_nxt;
      image_addr  <= addr_nxt;
      in_cnt      <= in_cnt_nxt;
      out_cnt     <= out_cnt_nxt;
      wd_cnt      <= wd_cnt_nxt;
      error       <= error_nxt;
      read_kernel <= (state_nxt == KERNEL) && (state != KERNEL);
      read_image  <= (state_nxt == ISSUE);
      busy        <= (state_nxt != IDLE);
      done        <= (state_nxt == DONE);
    end
  end

endmodule
